// File: rtl/axis_packet_src_pkg.sv
// axis_packet_src_pkg
//   Types and constants shared by the AXI-Stream packet source.
//   - state_e : burst sequencer states
//   - LEN_LSB : bit offset of the len field inside config_packet
//   - k_lsb() : bit offset of the k field (equal to the data width DW)
//   - GAP_CW  : width of the inter-packet gap down-counter (GAP is 0..15)
package axis_packet_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int LEN_LSB = 0;
    localparam int GAP_CW  = 4;

    // The k field sits directly above len, so its offset equals DW.
    function automatic int k_lsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/axis_packet_src.sv
// axis_packet_src
//   Emits a burst of k packets of len beats each on an AXI-Stream master
//   port. Data starts at seed and increments by one per accepted beat,
//   continuing across packet boundaries. GAP idle cycles separate packets.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous active-low reset
//   start         : one-cycle burst request, honoured only when idle
//   config_packet : {k, len}, k = packets per burst, len = beats per packet
//   seed          : first data value of the burst
//   m_tdata       : stream data
//   m_tvalid      : stream valid
//   m_tlast       : high on the final beat of each packet
//   m_tready      : stream ready from the sink
//   busy          : high while not idle
//   done          : one-cycle pulse after the final beat of the burst
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// SEND    | m_tvalid high, beats transfer on m_tready
// GAP     | m_tvalid low for GAP cycles between packets
// DONE    | done pulse; entered early (done still low) for an empty burst
module axis_packet_src
    import axis_packet_src_pkg::*;
#(
    parameter int DW  = 8,
    parameter int GAP = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] config_packet,
    input  logic [DW-1:0]   seed,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tvalid,
    output logic            m_tlast,
    input  logic            m_tready,
    output logic            busy,
    output logic            done
);

    localparam int K_LSB = k_lsb(DW);
    localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    state_e              state_q;
    logic [DW-1:0]       k_q;
    logic [DW-1:0]       len_q;
    logic [DW-1:0]       beat_q;
    logic [DW-1:0]       pkt_q;
    logic [DW-1:0]       data_q;
    logic [GAP_CW-1:0]   gap_q;
    logic                m_tvalid_q;
    logic                m_tlast_q;
    logic                busy_q;
    logic                done_q;

    logic [DW-1:0]       cfg_k;
    logic [DW-1:0]       cfg_len;

    logic [DW-1:0]       beat_d;
    logic [DW-1:0]       pkt_d;
    logic [DW-1:0]       data_d;
    logic                last_pkt_d;
    logic                len_one_d;
    logic                next_last_d;

    assign cfg_k   = config_packet[K_LSB +: DW];
    assign cfg_len = config_packet[LEN_LSB +: DW];

    // Inlined up-counters and their terminal compares.
    always_comb begin
        beat_d      = beat_q + DW'(1);
        pkt_d       = pkt_q + DW'(1);
        data_d      = data_q + DW'(1);
        last_pkt_d  = (pkt_d == k_q);
        len_one_d   = (len_q == DW'(1));
        next_last_d = (beat_d == len_q - DW'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            pkt_q      <= '0;
            data_q     <= '0;
            gap_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        k_q    <= cfg_k;
                        len_q  <= cfg_len;
                        data_q <= seed;
                        beat_q <= '0;
                        pkt_q  <= '0;
                        busy_q <= 1'b1;
                        if (cfg_k == '0 || cfg_len == '0) begin
                            // Empty burst: one cycle in DONE with done low,
                            // then the pulse, so no beat is ever offered.
                            state_q <= ST_DONE;
                        end else begin
                            state_q    <= ST_SEND;
                            m_tvalid_q <= 1'b1;
                            m_tlast_q  <= (cfg_len == DW'(1));
                        end
                    end
                end

                ST_SEND: begin
                    if (m_tvalid_q && m_tready) begin
                        data_q <= data_d;
                        if (m_tlast_q) begin
                            pkt_q  <= pkt_d;
                            beat_q <= '0;
                            if (last_pkt_d) begin
                                state_q    <= ST_DONE;
                                m_tvalid_q <= 1'b0;
                                m_tlast_q  <= 1'b0;
                                done_q     <= 1'b1;
                            end else if (GAP > 0) begin
                                state_q    <= ST_GAP;
                                m_tvalid_q <= 1'b0;
                                m_tlast_q  <= 1'b0;
                                gap_q      <= GAP_LOAD;
                            end else begin
                                m_tlast_q <= len_one_d;
                            end
                        end else begin
                            beat_q    <= beat_d;
                            m_tlast_q <= next_last_d;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q    <= ST_SEND;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= len_one_d;
                    end else begin
                        gap_q <= gap_q - GAP_CW'(1);
                    end
                end

                ST_DONE: begin
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_tdata  = data_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_axis_packet_src.sv
// Bench for axis_packet_src: two instances (GAP=0 and GAP=2) share the
// same stimulus. Expected beats come from a burst model: beat n of a burst
// carries (seed + n) mod 256 and is last when n mod len = len-1.
module tb_axis_packet_src;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   cfg;
    logic [7:0]    seed;
    logic          tready;

    logic [7:0]    tdata  [2];
    logic          tvalid [2];
    logic          tlast  [2];
    logic          busy   [2];
    logic          done   [2];

    int vectors;
    int miscompares;

    // per-instance tracker state
    logic        prev_v [2];
    logic        prev_l [2];
    logic [7:0]  prev_d [2];
    logic        prev_r;
    int          acc     [2];
    bit          fin     [2];
    bit          in_gap  [2];
    int          gap_run [2];

    axis_packet_src #(.DW(DW), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .config_packet(cfg), .seed(seed),
        .m_tdata(tdata[0]), .m_tvalid(tvalid[0]), .m_tlast(tlast[0]),
        .m_tready(tready), .busy(busy[0]), .done(done[0])
    );

    axis_packet_src #(.DW(DW), .GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .config_packet(cfg), .seed(seed),
        .m_tdata(tdata[1]), .m_tvalid(tvalid[1]), .m_tlast(tlast[1]),
        .m_tready(tready), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input int i, input string s);
        return $sformatf("g%0d_%s", gap_of(i), s);
    endfunction

    // One sample point (1 time unit after a rising edge) for instance i.
    task automatic proc(input int i, input int cyc, input int total, input int len,
                        input logic [7:0] sd, input int exp_done);
        logic       acc_prev;
        logic [7:0] e_data;
        logic       e_last;
        acc_prev = prev_v[i] && prev_r;
        if (fin[i]) begin
            chk(tg(i, "idle_done"), {31'd0, done[i]}, 0);
            chk(tg(i, "idle_valid"), {31'd0, tvalid[i]}, 0);
            chk(tg(i, "idle_busy"), {31'd0, busy[i]}, 0);
            return;
        end
        chk(tg(i, "busy"), {31'd0, busy[i]}, 1);
        if (acc_prev) begin
            acc[i]++;
            if (prev_l[i] && acc[i] < total) begin
                in_gap[i]  = 1'b1;
                gap_run[i] = 0;
            end
        end
        if (tvalid[i]) begin
            if (in_gap[i]) begin
                chk(tg(i, "gap_len"), gap_run[i], gap_of(i));
                in_gap[i] = 1'b0;
            end
            if (prev_v[i] && !prev_r) begin
                chk(tg(i, "hold_data"), {24'd0, tdata[i]}, {24'd0, prev_d[i]});
                chk(tg(i, "hold_last"), {31'd0, tlast[i]}, {31'd0, prev_l[i]});
            end else begin
                chk(tg(i, "extra_beat"), {31'd0, acc[i] < total}, 1);
                if (acc[i] < total) begin
                    e_data = sd + 8'(acc[i]);
                    e_last = ((acc[i] % len) == len - 1);
                    chk(tg(i, "data"), {24'd0, tdata[i]}, {24'd0, e_data});
                    chk(tg(i, "last"), {31'd0, tlast[i]}, {31'd0, e_last});
                end
            end
        end else begin
            if (prev_v[i] && !prev_r)
                chk(tg(i, "valid_hold"), {31'd0, tvalid[i]}, 1);
            if (in_gap[i]) gap_run[i]++;
        end
        if (cyc == 1 && total > 0)
            chk(tg(i, "first_valid"), {31'd0, tvalid[i]}, 1);
        if (exp_done >= 0 && cyc == exp_done)
            chk(tg(i, "done_at"), {31'd0, done[i]}, 1);
        if (done[i]) begin
            chk(tg(i, "done_beats"), acc[i], total);
            if (total > 0) chk(tg(i, "done_after_last"), {31'd0, acc_prev}, 1);
            if (exp_done >= 0) chk(tg(i, "done_cycle"), cyc, exp_done);
            fin[i] = 1'b1;
        end
    endtask

    // mode 0: ready always 1, mode 1: ready toggles 1/0, mode 2: random ready
    // plus ignored start pulses. abort_at > 0 returns after that many beats.
    task automatic run_burst(input int k, input int len, input logic [7:0] sd,
                             input int mode, input int abort_at);
        int total;
        int budget;
        int cyc;
        int exp_done [2];
        total  = k * len;
        budget = total * 4 + 60;
        for (int i = 0; i < 2; i++) begin
            prev_v[i] = 1'b0; prev_l[i] = 1'b0; prev_d[i] = '0;
            acc[i] = 0; fin[i] = 1'b0; in_gap[i] = 1'b0; gap_run[i] = 0;
            if (total == 0)           exp_done[i] = 2;
            else if (mode == 0)       exp_done[i] = total + (k - 1) * gap_of(i) + 1;
            else if (mode == 1 && k == 1) exp_done[i] = 2 * len;
            else                      exp_done[i] = -1;
        end
        cfg    = {8'(k), 8'(len)};
        seed   = sd;
        start  = 1'b1;
        tready = 1'b1;
        prev_r = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg   = 16'($urandom);
        seed  = 8'($urandom);
        cyc   = 1;
        while (cyc <= budget) begin
            for (int i = 0; i < 2; i++) proc(i, cyc, total, len, sd, exp_done[i]);
            if (abort_at > 0 && acc[0] >= abort_at) return;
            if (fin[0] && fin[1]) break;
            case (mode)
                0:       tready = 1'b1;
                1:       tready = cyc[0];
                default: tready = ($urandom_range(0, 3) != 0);
            endcase
            start = (mode == 2 && !fin[0] && !fin[1] && $urandom_range(0, 7) == 0);
            prev_r = tready;
            for (int i = 0; i < 2; i++) begin
                prev_v[i] = tvalid[i]; prev_l[i] = tlast[i]; prev_d[i] = tdata[i];
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (!(fin[0] && fin[1])) chk("burst_timeout", {31'd0, fin[0] && fin[1]}, 1);
        start  = 1'b0;
        tready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk(tg(i, "post_busy"), {31'd0, busy[i]}, 0);
            chk(tg(i, "post_done"), {31'd0, done[i]}, 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b0;
        start  = 1'b0;
        cfg    = '0;
        seed   = '0;
        tready = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk(tg(i, "rst_valid"), {31'd0, tvalid[i]}, 0);
            chk(tg(i, "rst_last"), {31'd0, tlast[i]}, 0);
            chk(tg(i, "rst_data"), {24'd0, tdata[i]}, 0);
            chk(tg(i, "rst_busy"), {31'd0, busy[i]}, 0);
            chk(tg(i, "rst_done"), {31'd0, done[i]}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        run_burst(2, 64, 8'h00, 0, 0);
        run_burst(1, 4, 8'hFE, 0, 0);
        run_burst(1, 8, 8'h00, 1, 0);
        run_burst(3, 2, 8'h00, 0, 0);
        run_burst(0, 5, 8'h07, 0, 0);
        run_burst(4, 0, 8'h07, 0, 0);
        run_burst(1, 1, 8'hFF, 0, 0);

        run_burst(2, 64, 8'h30, 0, 10);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(tg(i, "midrst_valid"), {31'd0, tvalid[i]}, 0);
            chk(tg(i, "midrst_last"), {31'd0, tlast[i]}, 0);
            chk(tg(i, "midrst_data"), {24'd0, tdata[i]}, 0);
            chk(tg(i, "midrst_busy"), {31'd0, busy[i]}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk(tg(i, "after_rst_valid"), {31'd0, tvalid[i]}, 0);
        run_burst(2, 64, 8'h30, 0, 0);

        for (int n = 0; n < 12; n++) begin
            run_burst($urandom_range(1, 4), $urandom_range(1, 12), 8'($urandom), 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_packet_src.md
AXIS_PACKET_SRC -- requirements
Module: axis_packet_src

Interface
REQ-001 Parameter DW, default 8, data width and width of each config field.
REQ-002 Parameter GAP, default 0, idle cycles inserted between packets (0..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a burst; ignored unless state is IDLE.
REQ-006 config_packet  input  2*DW  {k, len}: k = packets per burst in [2*DW-1:DW], len = beats per packet in [DW-1:0].
REQ-007 seed  input  DW  first data value of the burst.
REQ-008 m_tdata  output  DW  AXI-Stream data.
REQ-009 m_tvalid  output  1  AXI-Stream valid.
REQ-010 m_tlast  output  1  high on the final beat of each packet.
REQ-011 m_tready  input  1  AXI-Stream ready from the downstream sink.
REQ-012 busy  output  1  high while state is not IDLE.
REQ-013 done  output  1  one-cycle pulse after the final beat of the burst is accepted.

Function
REQ-014 States: IDLE, SEND, GAP, DONE.
REQ-015 IDLE: on start=1, latch config_packet and seed; go to SEND next cycle; if latched k=0 or len=0, go to DONE instead and emit no beats.
REQ-016 SEND: m_tvalid=1; a beat transfers only when m_tvalid && m_tready.
REQ-017 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tvalid hold stable.
REQ-018 Data pattern: first beat = seed; each accepted beat increments m_tdata by 1, modulo 2^DW (0xFF wraps to 0x00); the pattern continues across packet boundaries.
REQ-019 Beat counter counts 0..len-1; m_tlast=1 exactly when beat counter = len-1.
REQ-020 On accepted tlast beat: packet counter increments; if packets sent = k, go to DONE; else if GAP>0, go to GAP; else stay in SEND with beat counter cleared (back-to-back, no bubble).
REQ-021 GAP: m_tvalid=0 for exactly GAP cycles, then return to SEND.
REQ-022 DONE: done=1 for one cycle, m_tvalid=0; go to IDLE next cycle.
REQ-023 start while busy=1 is ignored; config_packet/seed changes mid-burst have no effect.
REQ-024 All outputs are registered; first valid beat appears one cycle after the start cycle.
REQ-025 Counters are DW bits; len and k are unsigned, max 2^DW-1 each.
REQ-026 With m_tready held at 1 and GAP=0, throughput = 1 beat/cycle; a burst occupies k*len SEND cycles.

Reset
REQ-027 rst=0 asynchronously forces: state IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, all counters 0.
REQ-028 Reset mid-burst abandons the burst immediately; no partial-packet completion; after release, the block waits for a new start.
REQ-029 Deassertion of rst is synchronous to clk; the first start is accepted on the first rising edge with rst=1.

Structure
REQ-030 Shared package holds the state enum type and the config field offsets (K_LSB=DW, LEN_LSB=0).
REQ-031 Single module, no sub-modules; a DW-bit up-counter is inlined for the beat and packet counts.

Verification
REQ-032 k=2, len=64, seed=0, m_tready=1 -> 128 beats 0..127, tlast at beats 63 and 127, done pulse 1 cycle after beat 127, busy low afterwards.
REQ-033 k=1, len=4, seed=0xFE -> data FE, FF, 00, 01, tlast on 01 (wrap check).
REQ-034 k=1, len=8, m_tready toggled 1/0 each cycle -> data and tlast stable during stalls; 8 beats 0..7 in 16 cycles, no drops or duplicates.
REQ-035 k=3, len=2, GAP=2 -> pattern V V x x V V x x V V, tlast on each second beat, data 0..5.
REQ-036 k=0 or len=0 with start -> no m_tvalid; done pulse 2 cycles after start.
REQ-037 rst=0 asserted after 10 beats of k=2, len=64 -> m_tvalid=0 immediately; a new start after release restarts from seed with beat 0.
